// File: rtl/soc_bus_decoder.sv
// rtl/soc_bus_decoder.sv - single-master to NSLV-slave address decoder with per-transaction timeout
module soc_bus_decoder #(
  parameter int                 NSLV     = 2,
  parameter int                 AW       = 32,
  parameter int                 DW       = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h0000_1000, 32'h0000_0000},
  parameter logic [NSLV*AW-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_FF00},
  parameter int                 TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [AW-1:0]      addr,
  input  logic               rw,
  input  logic [DW-1:0]      dwrite,
  input  logic               valid,
  output logic [DW-1:0]      dread,
  output logic               done,
  output logic               err,
  output logic [AW-1:0]      s_addr,
  output logic               s_rw,
  output logic [DW-1:0]      s_dwrite,
  output logic [NSLV-1:0]    s_valid,
  input  logic [NSLV*DW-1:0] s_dread,
  input  logic [NSLV-1:0]    s_done
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state;
  logic [15:0]   cnt;
  logic [15:0]   cnt_inc;
  logic [SW-1:0] sel;

  logic          hit;
  logic [SW-1:0] hit_idx;
  logic [AW-1:0] hit_mask;
  logic          sel_done;
  logic [DW-1:0] sel_dread;

  // Scan from the top slot down so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_mask = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit      = 1'b1;
        hit_idx  = SW'(i);
        hit_mask = SLV_MASK[i*AW +: AW];
      end
    end
  end

  assign sel_done  = s_done[sel];
  assign sel_dread = s_dread[int'(sel)*DW +: DW];
  assign cnt_inc   = cnt + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sel      <= '0;
      dread    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      s_addr   <= '0;
      s_rw     <= 1'b0;
      s_dwrite <= '0;
      s_valid  <= '0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      s_valid <= '0;
      case (state)
        IDLE: begin
          if (valid) begin
            s_rw     <= rw;
            s_dwrite <= dwrite;
            cnt      <= '0;
            if (hit) begin
              sel     <= hit_idx;
              s_addr  <= addr & ~hit_mask;
              s_valid <= NSLV'(1) << hit_idx;
              state   <= REQ;
            end else begin
              s_addr <= addr;
              dread  <= '0;
              done   <= 1'b1;
              err    <= 1'b1;
              state  <= RESP;
            end
          end
        end
        REQ, BUSY: begin
          // A slave may answer while its s_valid is still high, so REQ accepts s_done too.
          if (sel_done) begin
            dread <= s_rw ? '0 : sel_dread;
            done  <= 1'b1;
            state <= RESP;
          end else if (state == BUSY && cnt_inc == 16'(TIMEOUT)) begin
            dread <= '0;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= RESP;
          end else begin
            if (state == BUSY) begin
              cnt <= cnt_inc;
            end
            state <= BUSY;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_decoder.sv
// tb/tb_soc_bus_decoder.sv - directed bench with a cycle-indexed expectation model for soc_bus_decoder
module tb_soc_bus_decoder;

  localparam int          TO    = 255;
  localparam int          CM    = 4095;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] MASK0 = 32'hFFFF_FF00;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam logic [31:0] MASK1 = 32'hFFFF_F000;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr    = '0;
  logic        rw      = 1'b0;
  logic [31:0] dwrite  = '0;
  logic        valid   = 1'b0;
  logic [31:0] dread;
  logic        done;
  logic        err;
  logic [31:0] s_addr;
  logic        s_rw;
  logic [31:0] s_dwrite;
  logic [1:0]  s_valid;
  logic [63:0] s_dread = '0;
  logic [1:0]  s_done  = '0;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int n0;

  // Expected outputs indexed by cycle number; cycle n is the interval after the n-th rising edge.
  bit        exp_done [0:CM];
  bit        exp_err  [0:CM];
  bit [31:0] exp_dr   [0:CM];
  bit [1:0]  exp_sv   [0:CM];
  bit        exp_hold [0:CM];
  bit [31:0] exp_sa   [0:CM];
  bit        exp_srw  [0:CM];
  bit [31:0] exp_sdw  [0:CM];
  bit [31:0] model_dread = '0;

  logic [1:0]  cap_sv;
  logic [31:0] cap_sa;
  logic [31:0] cap_sdw;
  logic        cap_srw;
  logic        cap_done;
  logic        cap_err;

  soc_bus_decoder #(
    .NSLV    (2),
    .AW      (32),
    .DW      (32),
    .SLV_BASE({BASE1, BASE0}),
    .SLV_MASK({MASK1, MASK0}),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .rw      (rw),
    .dwrite  (dwrite),
    .valid   (valid),
    .dread   (dread),
    .done    (done),
    .err     (err),
    .s_addr  (s_addr),
    .s_rw    (s_rw),
    .s_dwrite(s_dwrite),
    .s_valid (s_valid),
    .s_dread (s_dread),
    .s_done  (s_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int decode(input logic [31:0] a);
    if ((a & MASK0) == BASE0) return 0;
    if ((a & MASK1) == BASE1) return 1;
    return -1;
  endfunction

  task automatic expect_done(input int n, input bit e, input bit [31:0] d);
    exp_done[n & CM] = 1'b1;
    exp_err[n & CM]  = e;
    exp_dr[n & CM]   = d;
  endtask

  task automatic expect_hold(input int from, input int upto, input bit [31:0] sa,
                             input bit srw, input bit [31:0] sdw);
    for (int n = from; n <= upto; n++) begin
      exp_hold[n & CM] = 1'b1;
      exp_sa[n & CM]   = sa;
      exp_srw[n & CM]  = srw;
      exp_sdw[n & CM]  = sdw;
    end
  endtask

  always @(negedge clk) begin : compare
    int c;
    c = cyc & CM;
    if (!reset_n) begin
      model_dread = '0;
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_s_valid", 64'(s_valid), 64'(0));
      check("rst_dread", 64'(dread), 64'(0));
      check("rst_s_addr", 64'(s_addr), 64'(0));
      check("rst_s_rw", 64'(s_rw), 64'(0));
      check("rst_s_dwrite", 64'(s_dwrite), 64'(0));
    end else begin
      if (exp_done[c]) model_dread = exp_dr[c];
      check("done", 64'(done), 64'(exp_done[c]));
      check("err", 64'(err), 64'(exp_done[c] & exp_err[c]));
      check("s_valid", 64'(s_valid), 64'(exp_sv[c]));
      check("dread", 64'(dread), 64'(model_dread));
      if (exp_hold[c]) begin
        check("s_addr", 64'(s_addr), 64'(exp_sa[c]));
        check("s_rw", 64'(s_rw), 64'(exp_srw[c]));
        check("s_dwrite", 64'(s_dwrite), 64'(exp_sdw[c]));
      end
    end
    exp_done[c] = 1'b0;
    exp_err[c]  = 1'b0;
    exp_dr[c]   = '0;
    exp_sv[c]   = '0;
    exp_hold[c] = 1'b0;
  end

  // d: cycles after the request cycle at which the slave pulses s_done (0 = during s_valid).
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] wd, input int d,
                     input logic [31:0] rd, input int stray_at, input bit poke);
    int          s, k, dc, t;
    logic [31:0] m;
    s = cyc;
    k = decode(a);
    addr   = a;
    rw     = w;
    dwrite = wd;
    valid  = 1'b1;
    if (k < 0) begin
      expect_done(s + 1, 1'b1, '0);
      step;
      cap_sv = s_valid; cap_sa = s_addr; cap_srw = s_rw; cap_sdw = s_dwrite;
      cap_done = done; cap_err = err;
      valid = 1'b0;
      step;
      return;
    end
    m = (k == 0) ? MASK0 : MASK1;
    exp_sv[(s + 1) & CM] = (k == 0) ? 2'b01 : 2'b10;
    if (d <= TO) begin
      dc = s + 2 + d;
      expect_done(dc, 1'b0, w ? 32'h0 : rd);
    end else begin
      dc = s + 2 + TO;
      expect_done(dc, 1'b1, '0);
    end
    expect_hold(s + 1, dc, a & ~m, w, wd);
    s_dread = {~rd, ~rd};
    s_dread[k*32 +: 32] = rd;
    step;
    cap_sv = s_valid; cap_sa = s_addr; cap_srw = s_rw; cap_sdw = s_dwrite;
    cap_done = done; cap_err = err;
    valid = 1'b0;
    while (cyc < dc) begin
      t = cyc - s - 1;
      s_done = '0;
      if (t == d) s_done[k] = 1'b1;
      if (t == stray_at) s_done[1-k] = 1'b1;
      if (poke && t == 1) begin
        valid = 1'b1;
        addr  = 32'h0000_8000;
      end else begin
        valid = 1'b0;
      end
      step;
    end
    s_done = '0;
    valid  = 1'b0;
    step;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within 1 ms");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", 64'(done), 64'(0));
    check("reset_err", 64'(err), 64'(0));
    check("reset_s_valid", 64'(s_valid), 64'(0));
    check("reset_dread", 64'(dread), 64'(0));
    check("reset_s_addr", 64'(s_addr), 64'(0));
    check("reset_s_rw", 64'(s_rw), 64'(0));
    check("reset_s_dwrite", 64'(s_dwrite), 64'(0));
    reset_n = 1'b1;
    step;

    txn(32'h0000_0010, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, -1, 1'b0);
    check("rd0_s_valid", 64'(cap_sv), 64'(2'b01));
    check("rd0_s_addr", 64'(cap_sa), 64'(32'h10));
    check("rd0_dread", 64'(dread), 64'(32'hDEAD_BEEF));

    txn(32'h0000_1004, 1'b1, 32'hA5A5_1234, 2, 32'h1111_2222, -1, 1'b0);
    check("wr1_s_valid", 64'(cap_sv), 64'(2'b10));
    check("wr1_s_addr", 64'(cap_sa), 64'(32'h004));
    check("wr1_s_rw", 64'(cap_srw), 64'(1));
    check("wr1_s_dwrite", 64'(cap_sdw), 64'(32'hA5A5_1234));
    check("wr1_dread", 64'(dread), 64'(0));

    txn(32'h0000_2000, 1'b0, 32'h0, 0, 32'h0, -1, 1'b0);
    check("miss_s_valid", 64'(cap_sv), 64'(0));
    check("miss_done", 64'(cap_done), 64'(1));
    check("miss_err", 64'(cap_err), 64'(1));
    check("miss_dread", 64'(dread), 64'(0));

    txn(32'h0000_0044, 1'b0, 32'h0, 0, 32'h1234_5678, -1, 1'b0);
    check("same_cycle_dread", 64'(dread), 64'(32'h1234_5678));

    txn(32'h0000_1FFC, 1'b0, 32'h0, 5, 32'hCAFE_F00D, 2, 1'b1);
    check("stray_s_addr", 64'(cap_sa), 64'(32'hFFC));
    check("stray_dread", 64'(dread), 64'(32'hCAFE_F00D));

    txn(32'h0000_00FC, 1'b1, 32'h0F0F_0F0F, 1, 32'h7777_7777, -1, 1'b0);
    check("wr0_dread", 64'(dread), 64'(0));

    n0 = cyc;
    expect_done(n0 + 1, 1'b1, '0);
    expect_done(n0 + 3, 1'b1, '0);
    addr  = 32'h0000_8000;
    rw    = 1'b0;
    valid = 1'b1;
    repeat (3) step;
    valid = 1'b0;
    repeat (2) step;

    txn(32'h0000_1FF0, 1'b0, 32'h0, TO, 32'h0BAD_CAFE, -1, 1'b0);
    check("last_busy_dread", 64'(dread), 64'(32'h0BAD_CAFE));

    n0 = cyc;
    addr   = 32'h0000_1008;
    rw     = 1'b0;
    dwrite = 32'h1357_9BDF;
    valid  = 1'b1;
    exp_sv[(n0 + 1) & CM] = 2'b10;
    expect_hold(n0 + 1, n0 + 4, 32'h008, 1'b0, 32'h1357_9BDF);
    step;
    valid = 1'b0;
    repeat (3) step;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_err", 64'(err), 64'(0));
    check("midrst_s_valid", 64'(s_valid), 64'(0));
    check("midrst_dread", 64'(dread), 64'(0));
    check("midrst_s_addr", 64'(s_addr), 64'(0));
    check("midrst_s_rw", 64'(s_rw), 64'(0));
    check("midrst_s_dwrite", 64'(s_dwrite), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step;

    txn(32'h0000_0020, 1'b0, 32'h0, 1, 32'h600D_600D, -1, 1'b0);
    check("post_rst_dread", 64'(dread), 64'(32'h600D_600D));

    txn(32'h0000_1000, 1'b0, 32'h0, TO + 100, 32'h5555_AAAA, -1, 1'b0);
    check("timeout_dread", 64'(dread), 64'(0));
    s_done = 2'b10;
    repeat (2) step;
    s_done = 2'b00;
    repeat (3) step;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/soc_bus_decoder.md
SOC_BUS_DECODER -- requirements
Module: soc_bus_decoder

Interface
REQ-001 SHALL have parameter NSLV, default 2: number of slave ports, 1..8.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameter SLV_BASE, default {32'h0000_1000, 32'h0000_0000}: packed NSLV x AW base addresses, slot 0 in LSBs.
REQ-005 SHALL have parameter SLV_MASK, default {32'hFFFF_F000, 32'hFFFF_FF00}: packed NSLV x AW region masks, slot 0 in LSBs.
REQ-006 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles before abort, 1..65535.
REQ-007 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-008 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port addr, input, AW: master address.
REQ-010 SHALL have port rw, input, 1: master direction, 1 = write, 0 = read.
REQ-011 SHALL have port dwrite, input, DW: master write data.
REQ-012 SHALL have port valid, input, 1: master request strobe.
REQ-013 SHALL have port dread, output, DW: read data returned to master.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse to master.
REQ-015 SHALL have port err, output, 1: qualifies done; 1 = decode miss or timeout.
REQ-016 SHALL have port s_addr, output, AW: latched address offset, addr & ~mask of selected slot.
REQ-017 SHALL have port s_rw, output, 1: latched direction.
REQ-018 SHALL have port s_dwrite, output, DW: latched write data.
REQ-019 SHALL have port s_valid, output, NSLV: one-hot request pulse, bit i for slave i.
REQ-020 SHALL have port s_dread, input, NSLV x DW: packed slave read data, slot 0 in LSBs.
REQ-021 SHALL have port s_done, input, NSLV: per-slave completion pulses.

Function
REQ-022 SHALL implement FSM states IDLE, REQ, BUSY, RESP.
REQ-023 In IDLE with valid=1, SHALL latch addr, rw and dwrite, and decode slot i where (addr & MASK[i]) == BASE[i]; on multiple matches the lowest index wins.
REQ-024 Match: SHALL go to REQ, asserting s_valid[i] for exactly the next cycle, then go to BUSY.
REQ-025 Miss: SHALL go to RESP and, in the cycle after valid, drive done=1, err=1 and dread=0; no s_valid bit asserts.
REQ-026 In BUSY, SHALL increment a cycle counter cleared on REQ entry, and watch only s_done[sel]; s_done from other slots is ignored.
REQ-027 On s_done[sel]=1 in cycle t, SHALL register s_dread[sel] into dread for reads (writes: dread=0), and pulse done=1, err=0 in cycle t+1.
REQ-028 A slave completing in the same cycle as s_valid (REQ) SHALL be accepted identically to REQ-027.
REQ-029 If the counter reaches TIMEOUT without s_done[sel], SHALL pulse done=1, err=1, dread=0 in the next cycle; a later s_done for that transaction is ignored.
REQ-030 RESP SHALL last exactly one cycle and then return to IDLE; done and err are 0 in every other state.
REQ-031 valid asserted outside IDLE SHALL be ignored; the master must re-present the request after done.
REQ-032 valid held high through RESP SHALL start a new transaction in the IDLE cycle following RESP (back-to-back rate: one request per 3 cycles minimum).
REQ-033 s_addr, s_rw and s_dwrite SHALL stay stable from REQ through RESP.
REQ-034 dread SHALL hold its value until the next done.

Reset
REQ-035 reset_n=0 SHALL immediately force state IDLE; counter, dread, s_addr, s_dwrite and selection to 0; done, err, s_rw and s_valid to 0.
REQ-036 Reset asserted mid-transaction SHALL abort it with no done pulse; the first request after reset_n rises is accepted normally.

Verification
REQ-037 Read at 32'h0000_0010 with slave 0 returning 32'hDEADBEEF after 3 cycles -> s_valid=2'b01, s_addr=32'h10, then done=1, err=0, dread=32'hDEADBEEF.
REQ-038 Write at 32'h0000_1004 -> s_valid=2'b10, s_addr=32'h004, s_rw=1, s_dwrite = dwrite; done with err=0 one cycle after s_done[1].
REQ-039 Read at 32'h0000_2000 -> no s_valid; done=1, err=1, dread=0 in the cycle after valid.
REQ-040 Slave 1 never responds, TIMEOUT=255 -> done=1, err=1 at cycle 255 of BUSY + 1; a subsequent s_done[1] produces no done.
REQ-041 Stray s_done[0] during a slave-1 access -> ignored; reset_n pulled low during BUSY -> all outputs 0 at once, no done; the next request completes normally.
